// File: rtl/klotski_move_selector.sv
// Cursor-driven source/destination tile picker for a Klotski board; emits one adjacent-tile move at a time.
// Optional macro KLOTSKI_CURSOR_WRAP_EN: cursor wraps at board edges instead of holding.
`default_nettype none

module klotski_move_selector #(
  parameter int COLS = 5,
  parameter int ROWS = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iKEY_UP,
  input  logic       iKEY_DOWN,
  input  logic       iKEY_LEFT,
  input  logic       iKEY_RIGHT,
  input  logic       iKEY_SEL,
  input  logic       iKEY_CANCEL,
  input  logic       iMoveAck,
  output logic [4:0] oCursor,
  output logic [4:0] oFromBlock,
  output logic [4:0] oToBlock,
  output logic       oMoveValid,
  output logic       oFromLatched,
  output logic       oReject,
  output logic [9:0] oMoveCount
);

  localparam logic [4:0] COLS_W   = 5'(COLS);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    PICK_FROM = 2'd0,
    PICK_TO   = 2'd1,
    COMMIT    = 2'd2
  } state_t;

  state_t     state_q;
  logic [4:0] row_q, col_q, row_d, col_d;
  logic [4:0] cursor_q, cursor_d;
  logic [4:0] from_q, from_row_q, from_col_q, to_q;
  logic       valid_q, latched_q, reject_q;
  logic [9:0] count_q;
  logic [4:0] row_diff, col_diff;
  logic       adjacent;

  // Cursor only moves when no higher-priority key (CANCEL/SEL) claims the cycle.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q != COMMIT && !iKEY_CANCEL && !iKEY_SEL) begin
      if (iKEY_UP) begin
`ifdef KLOTSKI_CURSOR_WRAP_EN
        row_d = (row_q == 5'd0) ? LAST_ROW : row_q - 5'd1;
`else
        if (row_q != 5'd0) row_d = row_q - 5'd1;
`endif
      end else if (iKEY_DOWN) begin
`ifdef KLOTSKI_CURSOR_WRAP_EN
        row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
`else
        if (row_q != LAST_ROW) row_d = row_q + 5'd1;
`endif
      end else if (iKEY_LEFT) begin
`ifdef KLOTSKI_CURSOR_WRAP_EN
        col_d = (col_q == 5'd0) ? LAST_COL : col_q - 5'd1;
`else
        if (col_q != 5'd0) col_d = col_q - 5'd1;
`endif
      end else if (iKEY_RIGHT) begin
`ifdef KLOTSKI_CURSOR_WRAP_EN
        col_d = (col_q == LAST_COL) ? 5'd0 : col_q + 5'd1;
`else
        if (col_q != LAST_COL) col_d = col_q + 5'd1;
`endif
      end
    end
    cursor_d = row_d * COLS_W + col_d;
  end

  // Row/col are kept separately so adjacency never wraps across row boundaries.
  always_comb begin
    row_diff = (row_q >= from_row_q) ? row_q - from_row_q : from_row_q - row_q;
    col_diff = (col_q >= from_col_q) ? col_q - from_col_q : from_col_q - col_q;
    adjacent = ({1'b0, row_diff} + {1'b0, col_diff}) == 6'd1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= PICK_FROM;
      row_q      <= 5'd0;
      col_q      <= 5'd0;
      cursor_q   <= 5'd0;
      from_q     <= 5'd0;
      from_row_q <= 5'd0;
      from_col_q <= 5'd0;
      to_q       <= 5'd0;
      valid_q    <= 1'b0;
      latched_q  <= 1'b0;
      reject_q   <= 1'b0;
      count_q    <= 10'd0;
    end else begin
      reject_q <= 1'b0;
      row_q    <= row_d;
      col_q    <= col_d;
      cursor_q <= cursor_d;
      unique case (state_q)
        PICK_FROM: begin
          if (!iKEY_CANCEL && iKEY_SEL) begin
            from_q     <= cursor_q;
            from_row_q <= row_q;
            from_col_q <= col_q;
            latched_q  <= 1'b1;
            state_q    <= PICK_TO;
          end
        end
        PICK_TO: begin
          if (iKEY_CANCEL) begin
            latched_q <= 1'b0;
            state_q   <= PICK_FROM;
          end else if (iKEY_SEL) begin
            if (adjacent) begin
              to_q    <= cursor_q;
              valid_q <= 1'b1;
              state_q <= COMMIT;
            end else begin
              reject_q  <= 1'b1;
              latched_q <= 1'b0;
              state_q   <= PICK_FROM;
            end
          end
        end
        COMMIT: begin
          if (iMoveAck) begin
            valid_q   <= 1'b0;
            latched_q <= 1'b0;
            if (count_q != 10'd1023) count_q <= count_q + 10'd1;
            state_q   <= PICK_FROM;
          end
        end
        default: state_q <= PICK_FROM;
      endcase
    end
  end

  assign oCursor      = cursor_q;
  assign oFromBlock   = from_q;
  assign oToBlock     = to_q;
  assign oMoveValid   = valid_q;
  assign oFromLatched = latched_q;
  assign oReject      = reject_q;
  assign oMoveCount   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_klotski_move_selector.sv
// Directed and randomized checks of klotski_move_selector against a board-level reference model.
`default_nettype none

module tb_klotski_move_selector;

  localparam int C = 5;
  localparam int R = 4;
`ifdef KLOTSKI_CURSOR_WRAP_EN
  localparam int EXP_EDGE_RIGHT = 0;
  localparam int EXP_EDGE_UP    = 15;
`else
  localparam int EXP_EDGE_RIGHT = 4;
  localparam int EXP_EDGE_UP    = 0;
`endif

  localparam logic [6:0] UP = 7'd1, DN = 7'd2, LF = 7'd4, RT = 7'd8;
  localparam logic [6:0] SEL = 7'd16, CAN = 7'd32, ACK = 7'd64, NONE = 7'd0;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b1;
  logic       iKEY_UP = 1'b0, iKEY_DOWN = 1'b0, iKEY_LEFT = 1'b0, iKEY_RIGHT = 1'b0;
  logic       iKEY_SEL = 1'b0, iKEY_CANCEL = 1'b0, iMoveAck = 1'b0;
  logic [4:0] oCursor, oFromBlock, oToBlock;
  logic       oMoveValid, oFromLatched, oReject;
  logic [9:0] oMoveCount;

  klotski_move_selector #(.COLS(C), .ROWS(R)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iKEY_UP(iKEY_UP), .iKEY_DOWN(iKEY_DOWN), .iKEY_LEFT(iKEY_LEFT), .iKEY_RIGHT(iKEY_RIGHT),
    .iKEY_SEL(iKEY_SEL), .iKEY_CANCEL(iKEY_CANCEL), .iMoveAck(iMoveAck),
    .oCursor(oCursor), .oFromBlock(oFromBlock), .oToBlock(oToBlock),
    .oMoveValid(oMoveValid), .oFromLatched(oFromLatched), .oReject(oReject),
    .oMoveCount(oMoveCount)
  );

  initial forever #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_mism = 0;

  // Reference model: 0 = choosing source, 1 = choosing destination, 2 = waiting for ack
  int m_state, m_row, m_col, m_from, m_to, m_valid, m_lat, m_rej, m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mism++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cursor"}, 32'(oCursor), 32'(m_row * C + m_col));
    check({tag, "_from"}, 32'(oFromBlock), 32'(m_from));
    check({tag, "_to"}, 32'(oToBlock), 32'(m_to));
    check({tag, "_valid"}, 32'(oMoveValid), 32'(m_valid));
    check({tag, "_latched"}, 32'(oFromLatched), 32'(m_lat));
    check({tag, "_reject"}, 32'(oReject), 32'(m_rej));
    check({tag, "_count"}, 32'(oMoveCount), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_state = 0; m_row = 0; m_col = 0; m_from = 0; m_to = 0;
    m_valid = 0; m_lat = 0; m_rej = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [6:0] k);
    int fr, fc, d;
    m_rej = 0;
    if (m_state == 2) begin
      if (k[6]) begin
        m_valid = 0; m_lat = 0; m_state = 0;
        m_cnt = (m_cnt < 1023) ? m_cnt + 1 : 1023;
      end
    end else if (k[5]) begin
      if (m_state == 1) begin m_lat = 0; m_state = 0; end
    end else if (k[4]) begin
      if (m_state == 0) begin
        m_from = m_row * C + m_col; m_lat = 1; m_state = 1;
      end else begin
        fr = m_from / C; fc = m_from % C;
        d = ((m_row > fr) ? m_row - fr : fr - m_row) + ((m_col > fc) ? m_col - fc : fc - m_col);
        if (d == 1) begin
          m_to = m_row * C + m_col; m_valid = 1; m_state = 2;
        end else begin
          m_rej = 1; m_lat = 0; m_state = 0;
        end
      end
    end else if (k[0]) begin
`ifdef KLOTSKI_CURSOR_WRAP_EN
      m_row = (m_row + R - 1) % R;
`else
      if (m_row > 0) m_row--;
`endif
    end else if (k[1]) begin
`ifdef KLOTSKI_CURSOR_WRAP_EN
      m_row = (m_row + 1) % R;
`else
      if (m_row < R - 1) m_row++;
`endif
    end else if (k[2]) begin
`ifdef KLOTSKI_CURSOR_WRAP_EN
      m_col = (m_col + C - 1) % C;
`else
      if (m_col > 0) m_col--;
`endif
    end else if (k[3]) begin
`ifdef KLOTSKI_CURSOR_WRAP_EN
      m_col = (m_col + 1) % C;
`else
      if (m_col < C - 1) m_col++;
`endif
    end
  endtask

  task automatic drive(input logic [6:0] k);
    iKEY_UP = k[0]; iKEY_DOWN = k[1]; iKEY_LEFT = k[2]; iKEY_RIGHT = k[3];
    iKEY_SEL = k[4]; iKEY_CANCEL = k[5]; iMoveAck = k[6];
  endtask

  task automatic step(input logic [6:0] k, input string tag);
    drive(k);
    @(posedge iCLK);
    #1;
    drive(NONE);
    model_step(k);
    check_all(tag);
  endtask

  // Reset asserted mid-cycle so the check proves it is asynchronous.
  task automatic do_reset(input string tag);
    iRST_N = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge iCLK);
    iRST_N = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] k;
    #2;
    do_reset("reset0");

    // Two-step move 6 -> 7, acked after 5 cycles of pending
    step(RT, "r32_rt"); step(DN, "r32_dn"); step(SEL, "r32_sel1");
    step(RT, "r32_rt2"); step(SEL, "r32_sel2");
    check("r32_fromblock", 32'(oFromBlock), 32'd6);
    check("r32_toblock", 32'(oToBlock), 32'd7);
    for (int i = 0; i < 5; i++) step(NONE, "r32_hold");
    step(ACK, "r32_ack");
    check("r32_valid_low", 32'(oMoveValid), 32'd0);
    check("r32_movecount", 32'(oMoveCount), 32'd1);

    // Non-adjacent destination rejected
    do_reset("reset1");
    step(SEL, "r33_sel1"); step(DN, "r33_dn1"); step(DN, "r33_dn2"); step(SEL, "r33_sel2");
    check("r33_reject", 32'(oReject), 32'd1);
    step(NONE, "r33_after");
    check("r33_reject_pulse", 32'(oReject), 32'd0);
    step(ACK, "r33_stray_ack");

    // Edge behaviour
    do_reset("reset2");
    for (int i = 0; i < 4; i++) step(RT, "r34_walk");
    step(RT, "r34_edge_right");
    check("r34_right_edge", 32'(oCursor), 32'(EXP_EDGE_RIGHT));
    do_reset("reset3");
    step(UP, "r34_edge_up");
    check("r34_up_edge", 32'(oCursor), 32'(EXP_EDGE_UP));
    step(LF, "r34_edge_left"); step(DN, "r34_dn");

    // SEL wins over LEFT in the same cycle
    do_reset("reset4");
    for (int i = 0; i < 3; i++) step(RT, "r35_walk");
    step(SEL | LF, "r35_sel_left");
    check("r35_from", 32'(oFromBlock), 32'd3);
    check("r35_cursor", 32'(oCursor), 32'd3);
    step(CAN | SEL, "r35_cancel");
    step(CAN, "r35_cancel_idle");

    // Keys ignored while pending, then reset drops the move
    do_reset("reset5");
    step(SEL, "r36_sel1"); step(RT, "r36_rt"); step(SEL, "r36_sel2");
    step(CAN | UP | DN, "r36_keys_in_commit");
    step(SEL | LF, "r36_sel_in_commit");
    do_reset("r36_reset_commit");
    check("r36_count_zero", 32'(oMoveCount), 32'd0);

    // Saturation of the move counter
    for (int i = 0; i < 1030; i++) begin
      step(SEL, "sat_sel1");
      step((i % 2 == 0) ? RT : LF, "sat_move");
      step(SEL, "sat_sel2");
      step(ACK, "sat_ack");
    end
    check("r36_saturate", 32'(oMoveCount), 32'd1023);

    // Randomized key pulses
    do_reset("reset6");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge iCLK);
        #3;
        do_reset("rand_reset");
      end else begin
        k = 7'($urandom) & 7'($urandom);
        if ($urandom_range(0, 3) == 0) k = k | SEL;
        step(k, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/klotski_move_selector.md
KLOTSKI_MOVE_SELECTOR -- requirements
Module: klotski_move_selector

Interface
REQ-001 SHALL have parameter COLS, default 5, board columns.
REQ-002 SHALL have parameter ROWS, default 4, board rows; COLS*ROWS <= 32.
REQ-003 SHALL have iCLK  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have iRST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have iKEY_UP, iKEY_DOWN, iKEY_LEFT, iKEY_RIGHT  input  1 each  debounced one-cycle cursor pulses.
REQ-006 SHALL have iKEY_SEL  input  1  one-cycle select pulse.
REQ-007 SHALL have iKEY_CANCEL  input  1  one-cycle cancel pulse.
REQ-008 SHALL have iMoveAck  input  1  downstream VGA stage accepts current move.
REQ-009 SHALL have oCursor  output  5  tile index under cursor, index = row*COLS + col.
REQ-010 SHALL have oFromBlock, oToBlock  output  5 each  move endpoints driven to VGA_Controller iFromBlock/iToBlock.
REQ-011 SHALL have oMoveValid  output  1  move pending, endpoints stable.
REQ-012 SHALL have oFromLatched  output  1  high while a source tile is held.
REQ-013 SHALL have oReject  output  1  one-cycle pulse on illegal move.
REQ-014 SHALL have oMoveCount  output  10  accepted move count.

Function
REQ-015 SHALL implement states PICK_FROM, PICK_TO, COMMIT; reset state PICK_FROM.
REQ-016 SHALL process at most one key per cycle, priority CANCEL > SEL > UP > DOWN > LEFT > RIGHT; lower-priority pulses in same cycle dropped.
REQ-017 SHALL update oCursor one cycle after a direction pulse in PICK_FROM or PICK_TO; UP decrements row, DOWN increments row, LEFT/RIGHT change col.
REQ-018 SHALL hold cursor at edges (no change) when KLOTSKI_CURSOR_WRAP_EN is undefined.
REQ-019 PICK_FROM + SEL: SHALL latch oFromBlock = oCursor, set oFromLatched, go PICK_TO next cycle.
REQ-020 PICK_TO + SEL: SHALL compute legality = Manhattan distance between cursor and oFromBlock equals exactly 1 (same-row horizontal or same-col vertical neighbour; no row wrap).
REQ-021 Legal: SHALL latch oToBlock = oCursor, assert oMoveValid, go COMMIT.
REQ-022 Illegal (including cursor == from): SHALL pulse oReject one cycle, clear oFromLatched, return PICK_FROM; oFromBlock retains last value.
REQ-023 PICK_TO + CANCEL: SHALL clear oFromLatched, return PICK_FROM, no reject pulse; CANCEL in PICK_FROM no effect.
REQ-024 COMMIT: SHALL hold oMoveValid, oFromBlock, oToBlock stable until iMoveAck high; all keys including CANCEL ignored.
REQ-025 iMoveAck in COMMIT: SHALL deassert oMoveValid and oFromLatched next cycle, increment oMoveCount, return PICK_FROM; ack outside COMMIT ignored.
REQ-026 oMoveCount SHALL saturate at 1023.
REQ-027 Cursor SHALL not move in COMMIT; cursor position preserved across all transitions.

Reset
REQ-028 Assertion of iRST_N low SHALL immediately force: state PICK_FROM, oCursor=0, oFromBlock=0, oToBlock=0, oMoveValid=0, oFromLatched=0, oReject=0, oMoveCount=0.
REQ-029 Reset mid-COMMIT SHALL drop the pending move without counting it.
REQ-030 After deassertion, first key SHALL be honoured on first rising edge.

Configuration
REQ-031 Macro KLOTSKI_CURSOR_WRAP_EN defined: cursor SHALL wrap (col COLS-1 RIGHT -> col 0 same row; row 0 UP -> row ROWS-1 same col, and symmetric); undefined: saturate per REQ-018. Legality rule REQ-020 unaffected.

Verification
REQ-032 Reset, RIGHT, DOWN, SEL, RIGHT, SEL, ack after 5 cycles -> oFromBlock=6, oToBlock=7, oMoveValid high 5 cycles then low, oMoveCount=1.
REQ-033 SEL at 0, DOWN DOWN, SEL -> oReject one-cycle pulse, oMoveValid stays 0, state PICK_FROM, oMoveCount=0.
REQ-034 Cursor 4, RIGHT -> oCursor 4 (undefined macro) / 0 (macro defined); cursor 0, UP -> 0 / 15.
REQ-035 Same-cycle SEL+LEFT at cursor 3 in PICK_FROM -> oFromBlock=3, oCursor remains 3.
REQ-036 Assert iRST_N low during COMMIT -> all outputs zero asynchronously, oMoveCount not incremented; 1024 acked moves -> oMoveCount=1023.
